stopwatch_clock_gen: RTL

STOPWATCH_CLOCK_GEN -- requirements
Module: stopwatch_clock_gen

---
 rtl/stopwatch_clock_gen.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_clock_gen.sv
// 24-hour clock plus 99-hour stopwatch multiplexed onto an active-low 7-segment display.
// Define STOPWATCH_LAP_EN to enable the lap-hold feature on i_lap.
module stopwatch_clock_gen #(
   parameter int unsigned CLK_HZ   = 100000000,
   parameter int unsigned SCAN_DIV = 100000,
   parameter int unsigned N_DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_add_sec,
   input  logic                i_add_min,
   input  logic                i_add_hr,
   input  logic                i_Sw_Clk,
   input  logic                i_Start_Stop,
   input  logic                i_reset,
   input  logic                i_lap,
   output logic                a,
   output logic                b,
   output logic                c,
   output logic                d,
   output logic                e,
   output logic                f,
   output logic                g,
   output logic                dp,
   output logic [N_DIGITS-1:0] an
);

   localparam int unsigned TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W  = 3;

   typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} sw_state_t;

   // Two-digit BCD increment that wraps to 00 once the field maximum is reached.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      if (v == max)
         return 8'h00;
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Active-low {a,b,c,d,e,f,g} hex decode.
   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      case (v)
         4'h0: return 7'b0000001;
         4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;
         4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;
         4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;
         4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;
         4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;
         4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

   logic              sec_q, min_q, hr_q, ss_q, rs_q;
   logic              sec_rise_c, min_rise_c, hr_rise_c, ss_rise_c, rs_rise_c;
   logic              adj_sec_c, adj_min_c, adj_hr_c, adj_any_c;
   logic [TICK_W-1:0] tick_cnt;
   logic              tick_c;
   logic [7:0]        clk_hh, clk_mm, clk_ss;
   logic [7:0]        sw_hh, sw_mm, sw_ss;
   sw_state_t         sw_state;
   logic [23:0]       disp_sw;
   logic [SCAN_W-1:0] scan_cnt;
   logic [IDX_W-1:0]  dig_idx;
   logic              disp_mode;
   logic [23:0]       show_c;
   logic [23:0]       win_c;
   logic [3:0]        digit_c;
   logic [6:0]        seg_q;
   logic              dp_q;
   logic [N_DIGITS-1:0] an_q;

   assign sec_rise_c = i_add_sec & ~sec_q;
   assign min_rise_c = i_add_min & ~min_q;
   assign hr_rise_c  = i_add_hr & ~hr_q;
   assign ss_rise_c  = i_Start_Stop & ~ss_q;
   assign rs_rise_c  = i_reset & ~rs_q;

   assign adj_sec_c = sec_rise_c & ~i_Sw_Clk;
   assign adj_min_c = min_rise_c & ~i_Sw_Clk;
   assign adj_hr_c  = hr_rise_c & ~i_Sw_Clk;
   assign adj_any_c = adj_sec_c | adj_min_c | adj_hr_c;

   assign tick_c = (tick_cnt == TICK_W'(CLK_HZ - 1));

   // Button edge samples and one-second tick counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         sec_q    <= 1'b0;
         min_q    <= 1'b0;
         hr_q     <= 1'b0;
         ss_q     <= 1'b0;
         rs_q     <= 1'b0;
         tick_cnt <= '0;
      end else begin
         sec_q    <= i_add_sec;
         min_q    <= i_add_min;
         hr_q     <= i_add_hr;
         ss_q     <= i_Start_Stop;
         rs_q     <= i_reset;
         tick_cnt <= tick_c ? '0 : tick_cnt + TICK_W'(1);
      end
   end

   // Time of day; an adjustment in the tick cycle swallows that tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_hh <= 8'h00;
         clk_mm <= 8'h00;
         clk_ss <= 8'h00;
      end else if (adj_any_c) begin
         if (adj_sec_c) clk_ss <= bcd_inc(clk_ss, 8'h59);
         if (adj_min_c) clk_mm <= bcd_inc(clk_mm, 8'h59);
         if (adj_hr_c)  clk_hh <= bcd_inc(clk_hh, 8'h23);
      end else if (tick_c) begin
         clk_ss <= bcd_inc(clk_ss, 8'h59);
         if (clk_ss == 8'h59) begin
            clk_mm <= bcd_inc(clk_mm, 8'h59);
            if (clk_mm == 8'h59)
               clk_hh <= bcd_inc(clk_hh, 8'h23);
         end
      end
   end

   // Stopwatch run/stop state and count; a clear edge overrides everything else.
   always_ff @(posedge clk) begin
      if (rst || rs_rise_c) begin
         sw_state <= STOPPED;
         sw_hh    <= 8'h00;
         sw_mm    <= 8'h00;
         sw_ss    <= 8'h00;
      end else begin
         if (tick_c && (sw_state == RUNNING)) begin
            sw_ss <= bcd_inc(sw_ss, 8'h59);
            if (sw_ss == 8'h59) begin
               sw_mm <= bcd_inc(sw_mm, 8'h59);
               if (sw_mm == 8'h59)
                  sw_hh <= bcd_inc(sw_hh, 8'h99);
            end
         end
         if (ss_rise_c)
            sw_state <= (sw_state == RUNNING) ? STOPPED : RUNNING;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic       lap_q, lap_rise_c, lap_hold;
   logic [7:0] lap_hh, lap_mm, lap_ss;

   assign lap_rise_c = i_lap & ~lap_q;

   // Lap hold freezes a snapshot for display while the count keeps running.
   always_ff @(posedge clk) begin
      if (rst) begin
         lap_q    <= 1'b0;
         lap_hold <= 1'b0;
         lap_hh   <= 8'h00;
         lap_mm   <= 8'h00;
         lap_ss   <= 8'h00;
      end else begin
         lap_q <= i_lap;
         if (rs_rise_c) begin
            lap_hold <= 1'b0;
         end else if (lap_rise_c && (sw_state == RUNNING)) begin
            lap_hold <= ~lap_hold;
            if (!lap_hold) begin
               lap_hh <= sw_hh;
               lap_mm <= sw_mm;
               lap_ss <= sw_ss;
            end
         end
      end
   end

   assign disp_sw = lap_hold ? {lap_hh, lap_mm, lap_ss} : {sw_hh, sw_mm, sw_ss};
`else
   logic unused_lap;
   assign unused_lap = i_lap;
   assign disp_sw    = {sw_hh, sw_mm, sw_ss};
`endif

   // Digit scan; the display mode is picked up only when moving to the next digit.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt  <= '0;
         dig_idx   <= '0;
         disp_mode <= 1'b0;
      end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
         scan_cnt  <= '0;
         dig_idx   <= (dig_idx == IDX_W'(N_DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);
         disp_mode <= i_Sw_Clk;
      end else begin
         scan_cnt <= scan_cnt + SCAN_W'(1);
      end
   end

   // Four-digit clock mode shows HH MM; every other case shows the low digits of HH MM SS.
   always_comb begin
      show_c  = disp_mode ? disp_sw : {clk_hh, clk_mm, clk_ss};
      win_c   = ((N_DIGITS == 4) && !disp_mode) ? {8'h00, show_c[23:8]} : show_c;
      digit_c = 4'd0;
      case (dig_idx)
         3'd0:    digit_c = win_c[3:0];
         3'd1:    digit_c = win_c[7:4];
         3'd2:    digit_c = win_c[11:8];
         3'd3:    digit_c = win_c[15:12];
         3'd4:    digit_c = win_c[19:16];
         3'd5:    digit_c = win_c[23:20];
         default: digit_c = 4'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q <= 7'h7F;
         dp_q  <= 1'b1;
         an_q  <= '1;
      end else begin
         seg_q <= seg_decode(digit_c);
         dp_q  <= ~((dig_idx == 3'd2) || ((N_DIGITS == 6) && (dig_idx == 3'd4)));
         an_q  <= ~(N_DIGITS'(1) << dig_idx);
      end
   end

   assign {a, b, c, d, e, f, g} = seg_q;
   assign dp = dp_q;
   assign an = an_q;

endmodule
